// File: rtl/mem_responder_pkg.sv
// Shared types for the 32-bit memory responder: FSM states, op encoding, latched request.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_responder_pkg;

  localparam int MEM_WORD_BYTES = 4;
  localparam int MEM_WORD_BITS  = 8 * MEM_WORD_BYTES;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } mem_resp_state_t;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } mem_op_t;

  // One request as seen on the bus; the latched copy and the live bus are
  // compared field-for-field by the protocol checker.
  typedef struct packed {
    logic [31:0]               addr;
    mem_op_t                   op;
    logic [MEM_WORD_BYTES-1:0] wmask;
    logic [MEM_WORD_BITS-1:0]  wdata;
  } mem_req_t;

  // Decode the live read/write strobes into an op. Only meaningful when
  // exactly one strobe is high; the checker flags the other cases.
  function automatic mem_op_t op_of(input logic wr);
    return wr ? OP_WRITE : OP_READ;
  endfunction

endpackage

// File: rtl/mem_resp_array.sv
// Word-addressed storage with per-byte write enables and one registered read port.
// Latency: write commits at the clock edge; read data appears one edge after ren.
// Backpressure: none; accepts a write and a read every cycle.
module mem_resp_array
  import mem_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DEPTH_LOG2-1:0]     widx,
  input  logic [MEM_WORD_BYTES-1:0] wbe,
  input  logic [MEM_WORD_BITS-1:0]  wdat,
  input  logic                      ren,
  input  logic [DEPTH_LOG2-1:0]     ridx,
  output logic [MEM_WORD_BITS-1:0]  rdat
);

  logic [MEM_WORD_BITS-1:0] mem [2**DEPTH_LOG2];

  // Byte-lane writes; storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < MEM_WORD_BYTES; b++) begin
      if (wbe[b]) begin
        mem[widx][8*b +: 8] <= wdat[8*b +: 8];
      end
    end
  end

  // Read output register: loads only when asked, otherwise holds its last word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdat <= '0;
    end else if (ren) begin
      rdat <= mem[ridx];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: byte-maskable word array plus initiator protocol checker.
// Latency: resp pulses LATENCY cycles after the request is sampled in IDLE.
// Backpressure: none; the initiator holds the request until resp, then may reissue at once.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               addr,
  input  logic                      read,
  input  logic                      write,
  input  logic [MEM_WORD_BYTES-1:0] wmask,
  input  logic [MEM_WORD_BITS-1:0]  wdata,
  output logic [MEM_WORD_BITS-1:0]  rdata,
  output logic                      resp,
  output logic                      error
);

  if (LATENCY < 1) begin : g_latency_check
    $error("mem_responder: LATENCY must be at least 1");
  end

  // WAIT counts down from LATENCY-2 to 0, so the counter only needs to hold LATENCY-2.
  localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY >= 2) ? CNT_W'(LATENCY - 2) : '0;

  mem_resp_state_t state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  mem_req_t         req_q;
  mem_req_t         req_live;
  logic             take;
  logic             load;
  logic             err_set;
  mem_op_t          nxt_op;
  logic [DEPTH_LOG2-1:0]     ridx;
  logic [DEPTH_LOG2-1:0]     widx;
  logic [MEM_WORD_BYTES-1:0] wbe;
  logic                      ren;

  assign req_live = '{addr: addr, op: op_of(write), wmask: wmask, wdata: wdata};

  // A request is taken in IDLE only when exactly one strobe is high; read&write is refused.
  assign take = (state == IDLE) && (read ^ write);

  // Next-state and counter logic.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (take) begin
          load = 1'b1;
          if (LATENCY == 1) begin
            state_nxt = RESP;
          end else begin
            cnt_nxt   = CNT_INIT;
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, counter and request latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      req_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (load) begin
        req_q <= req_live;
      end
    end
  end

  // Protocol violations: both strobes, misaligned request, or bus moving while in flight
  // (a dropped request shows up as read==write).
  always_comb begin
    err_set = 1'b0;
    if (read && write) begin
      err_set = 1'b1;
    end
    if (take && (addr[1:0] != 2'b00)) begin
      err_set = 1'b1;
    end
    if ((state != IDLE) && ((req_live != req_q) || (read == write))) begin
      err_set = 1'b1;
    end
  end

  // Sticky error flag and registered completion pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      error <= 1'b0;
      resp  <= 1'b0;
    end else begin
      if (err_set) begin
        error <= 1'b1;
      end
      resp <= (state_nxt == RESP);
    end
  end

  // With LATENCY==1 the read is launched on the same edge that samples the request,
  // so the index and op come straight from the bus while in IDLE.
  always_comb begin
    ridx   = req_q.addr[DEPTH_LOG2+1:2];
    nxt_op = req_q.op;
    if (state == IDLE) begin
      ridx   = addr[DEPTH_LOG2+1:2];
      nxt_op = op_of(write);
    end
  end

  assign ren  = (state_nxt == RESP) && (nxt_op == OP_READ);
  assign widx = req_q.addr[DEPTH_LOG2+1:2];
  assign wbe  = ((state == RESP) && (req_q.op == OP_WRITE)) ? req_q.wmask : '0;

  mem_resp_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk  (clk),
    .rst  (rst),
    .widx (widx),
    .wbe  (wbe),
    .wdat (req_q.wdata),
    .ren  (ren),
    .ridx (ridx),
    .rdat (rdata)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder built at LATENCY 2, 1 and 5.
// Latency: expected resp cycle is computed per request from the build's LATENCY.
// Backpressure: requests are held until their resp cycle has passed.
module tb_mem_responder;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] addr  [3];
  logic        rd    [3];
  logic        wr    [3];
  logic [3:0]  wmask [3];
  logic [31:0] wdata [3];
  logic [31:0] rdata [3];
  logic        resp  [3];
  logic        err   [3];

  mem_responder #(.DEPTH_LOG2(10), .LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst), .addr(addr[0]), .read(rd[0]), .write(wr[0]), .wmask(wmask[0]),
    .wdata(wdata[0]), .rdata(rdata[0]), .resp(resp[0]), .error(err[0]));

  mem_responder #(.DEPTH_LOG2(10), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .addr(addr[1]), .read(rd[1]), .write(wr[1]), .wmask(wmask[1]),
    .wdata(wdata[1]), .rdata(rdata[1]), .resp(resp[1]), .error(err[1]));

  mem_responder #(.DEPTH_LOG2(10), .LATENCY(5)) u_l5 (
    .clk(clk), .rst(rst), .addr(addr[2]), .read(rd[2]), .write(wr[2]), .wmask(wmask[2]),
    .wdata(wdata[2]), .rdata(rdata[2]), .resp(resp[2]), .error(err[2]));

  typedef struct {
    int          dut;
    int          cyc;
    logic [31:0] data;
    int          id;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 1 : 5);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  // Monitor: every resp pulse pops one expectation and checks DUT, cycle and rdata.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0) begin
      for (int d = 0; d < 3; d++) begin
        if (resp[d] !== 1'b0) begin
          if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_resp: dut %0d resp=%b at cycle %0d, none outstanding",
                     d, resp[d], cyc);
          end else begin
            e = sbq.pop_front();
            check($sformatf("resp%0d_dut", e.id), 32'(d), 32'(e.dut));
            check($sformatf("resp%0d_cycle", e.id), 32'(cyc), 32'(e.cyc));
            check($sformatf("resp%0d_rdata", e.id), rdata[d], e.data);
          end
        end
      end
    end
  end

  task automatic drive(input int d, input logic [31:0] a, input logic r, input logic w,
                       input logic [3:0] m, input logic [31:0] wd);
    addr[d]  = a;
    rd[d]    = r;
    wr[d]    = w;
    wmask[d] = m;
    wdata[d] = wd;
  endtask

  task automatic idle_all();
    for (int d = 0; d < 3; d++) drive(d, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int id, input int d, input logic [31:0] data);
    exp_t e;
    e.dut  = d;
    e.cyc  = cyc + lat_of(d);
    e.data = data;
    e.id   = id;
    sbq.push_back(e);
  endtask

  // Drive one request in an IDLE cycle, hold it through its resp cycle, return in the
  // following IDLE cycle with the request still on the bus (caller chains or idles).
  task automatic issue(input int id, input int d, input logic [31:0] a, input logic w,
                       input logic [3:0] m, input logic [31:0] wd, input logic [31:0] exp_rd);
    drive(d, a, !w, w, m, wd);
    push_exp(id, d, exp_rd);
    repeat (lat_of(d) + 1) @(posedge clk);
    #1;
  endtask

  task automatic reset_all();
    idle_all();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d responses outstanding", sbq.size());
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle_all();
    repeat (2) step();
    rst = 1'b0;
    step();
    for (int d = 0; d < 3; d++) begin
      check($sformatf("reset_resp_%0d", d), 32'(resp[d]), 32'h0);
      check($sformatf("reset_rdata_%0d", d), rdata[d], 32'h0);
      check($sformatf("reset_error_%0d", d), 32'(err[d]), 32'h0);
    end

    // Full write then read, LATENCY=2.
    issue(1, 0, 32'h10, 1'b1, 4'hF, 32'hDEADBEEF, 32'h0);
    issue(2, 0, 32'h10, 1'b0, 4'h0, 32'h0, 32'hDEADBEEF);
    idle_all(); step();
    check("error_after_basic", 32'(err[0]), 32'h0);

    // Partial write over DEADBEEF with lanes 0 and 2.
    issue(3, 0, 32'h10, 1'b1, 4'b0101, 32'h11223344, 32'hDEADBEEF);
    issue(4, 0, 32'h10, 1'b0, 4'h0, 32'h0, 32'hDE22BE44);
    idle_all(); step();

    // Back-to-back write then read of the same word, no idle gap.
    issue(5, 0, 32'h20, 1'b1, 4'hF, 32'hCAFEF00D, 32'hDE22BE44);
    issue(6, 0, 32'h20, 1'b0, 4'h0, 32'h0, 32'hCAFEF00D);
    idle_all(); step();

    // Zero-mask write completes but changes nothing.
    issue(7, 0, 32'h20, 1'b1, 4'h0, 32'hFFFFFFFF, 32'hCAFEF00D);
    issue(8, 0, 32'h20, 1'b0, 4'h0, 32'h0, 32'hCAFEF00D);
    idle_all(); step();

    // Aliasing: 0x1000 lands on word 0 with DEPTH_LOG2=10.
    issue(9, 0, 32'h1000, 1'b1, 4'hF, 32'hA5A50001, 32'hCAFEF00D);
    issue(10, 0, 32'h0, 1'b0, 4'h0, 32'h0, 32'hA5A50001);
    idle_all(); step();
    check("error_after_clean_traffic", 32'(err[0]), 32'h0);

    // LATENCY=1 and LATENCY=5 builds.
    issue(11, 1, 32'h40, 1'b1, 4'hF, 32'h0BADCAFE, 32'h0);
    issue(12, 1, 32'h40, 1'b0, 4'h0, 32'h0, 32'h0BADCAFE);
    idle_all(); step();
    issue(13, 2, 32'h44, 1'b1, 4'hF, 32'h600DF00D, 32'h0);
    issue(14, 2, 32'h44, 1'b0, 4'h0, 32'h0, 32'h600DF00D);
    idle_all(); step();
    check("error_lat1", 32'(err[1]), 32'h0);
    check("error_lat5", 32'(err[2]), 32'h0);

    // read&&write: refused, error sticky, FSM still idle for the next request.
    reset_all();
    drive(0, 32'h10, 1'b1, 1'b1, 4'hF, 32'h0);
    step();
    check("rw_error_rise", 32'(err[0]), 32'h1);
    idle_all();
    repeat (3) step();
    check("rw_error_sticky", 32'(err[0]), 32'h1);
    issue(15, 0, 32'h10, 1'b0, 4'h0, 32'h0, 32'hDE22BE44);
    idle_all(); step();

    // Misaligned read still completes on word 4.
    reset_all();
    check("misalign_error_pre", 32'(err[0]), 32'h0);
    issue(16, 0, 32'h13, 1'b0, 4'h0, 32'h0, 32'hDE22BE44);
    idle_all(); step();
    check("misalign_error", 32'(err[0]), 32'h1);

    // Address moves during WAIT: error, but resp on schedule with latched address.
    reset_all();
    drive(0, 32'h20, 1'b1, 1'b0, 4'h0, 32'h0);
    push_exp(17, 0, 32'hCAFEF00D);
    step();
    addr[0] = 32'h24;
    step();
    step();
    idle_all(); step();
    check("addr_change_error", 32'(err[0]), 32'h1);

    // Async reset mid-WAIT drops a write to a location pre-loaded with 0.
    issue(18, 0, 32'h30, 1'b1, 4'hF, 32'h0, 32'hCAFEF00D);
    idle_all(); step();
    drive(0, 32'h30, 1'b0, 1'b1, 4'hF, 32'h12345678);
    step();
    check("abort_error_before", 32'(err[0]), 32'h1);
    #2;
    rst = 1'b1;
    idle_all();
    #1;
    check("abort_resp", 32'(resp[0]), 32'h0);
    check("abort_error", 32'(err[0]), 32'h0);
    check("abort_rdata", rdata[0], 32'h0);
    step();
    rst = 1'b0;
    step();
    issue(19, 0, 32'h30, 1'b0, 4'h0, 32'h0, 32'h0);
    idle_all(); step();

    repeat (8) step();
    check("scoreboard_drained", 32'(sbq.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
